// File: rtl/qs_fifo_rr_arb_if.sv
// qs_fifo_rr_arb_if: handshake bundle between N_REQ producers, the
// round-robin push arbiter and the downstream qs_fifo write port.
//   req_valid_i      producer -> arbiter, per-requester valid
//   req_data_i       producer -> arbiter, packed data, slot i at [i*DATA_W +: DATA_W]
//   req_ready_o      arbiter -> producer, per-requester accept
//   fifo_push_o      arbiter -> qs_fifo push_i
//   fifo_push_data_o arbiter -> qs_fifo push_data_i
//   fifo_full_i      qs_fifo full_o -> arbiter
//   grant_valid_o    arbiter status: a requester is selected
//   grant_id_o       arbiter status: selected requester index
// master = arbiter side, slave = producers/FIFO side.
interface qs_fifo_rr_arb_if #(
    parameter int DATA_W = 8,
    parameter int N_REQ  = 2
);
    localparam int ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [N_REQ-1:0]        req_valid_i;
    logic [N_REQ*DATA_W-1:0] req_data_i;
    logic [N_REQ-1:0]        req_ready_o;
    logic                    fifo_push_o;
    logic [DATA_W-1:0]       fifo_push_data_o;
    logic                    fifo_full_i;
    logic                    grant_valid_o;
    logic [ID_W-1:0]         grant_id_o;

    modport master (
        input  req_valid_i, req_data_i, fifo_full_i,
        output req_ready_o, fifo_push_o, fifo_push_data_o, grant_valid_o, grant_id_o
    );

    modport slave (
        output req_valid_i, req_data_i, fifo_full_i,
        input  req_ready_o, fifo_push_o, fifo_push_data_o, grant_valid_o, grant_id_o
    );
endinterface

// File: rtl/qs_fifo_rr_arb.sv
// qs_fifo_rr_arb: round-robin push arbiter sharing one qs_fifo write port
// between N_REQ valid/ready producers. A grant may be held for up to
// MAX_BURST consecutive pushes so a producer's burst lands contiguously.
// The producer-to-FIFO path is purely combinational (zero latency).
// Ports:
//   clk    rising-edge clock
//   reset  synchronous, active-high; all outputs forced to 0 while high
//   bus    qs_fifo_rr_arb_if.master (requests, FIFO push, grant status)
module qs_fifo_rr_arb #(
    parameter int DATA_W    = 8,
    parameter int N_REQ     = 2,
    parameter int MAX_BURST = 2
) (
    input logic               clk,
    input logic               reset,
    qs_fifo_rr_arb_if.master  bus
);
    localparam int ID_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CNT_W = $clog2(MAX_BURST + 1);

    logic             lock_q;
    logic [ID_W-1:0]  owner_q;
    logic [ID_W-1:0]  last_q;
    logic [CNT_W-1:0] cnt_q;

    logic             any_valid;
    logic             cont;
    logic             found;
    logic             fire;
    logic [ID_W-1:0]  gnt;
    logic [ID_W-1:0]  idx_id;
    logic [CNT_W-1:0] cnt_next;
    int unsigned      idx;

    // Grant selection: keep the locked owner while it stays valid, otherwise
    // scan upward from the requester after the last one served.
    always_comb begin
        gnt    = '0;
        found  = 1'b0;
        idx    = 0;
        idx_id = '0;
        cont   = lock_q && bus.req_valid_i[owner_q];
        if (cont) begin
            gnt = owner_q;
        end else begin
            for (int unsigned k = 1; k <= N_REQ; k++) begin
                idx    = (32'(last_q) + k) % N_REQ;
                idx_id = ID_W'(idx);
                if (!found && bus.req_valid_i[idx_id]) begin
                    gnt   = idx_id;
                    found = 1'b1;
                end
            end
        end
    end

    assign any_valid = |bus.req_valid_i;
    assign fire      = !reset && any_valid && !bus.fifo_full_i;
    assign cnt_next  = cont ? cnt_q + 1'b1 : CNT_W'(1);

    always_comb begin
        bus.grant_valid_o    = 1'b0;
        bus.grant_id_o       = '0;
        bus.fifo_push_o      = fire;
        bus.fifo_push_data_o = '0;
        bus.req_ready_o      = '0;
        if (!reset && any_valid) begin
            bus.grant_valid_o    = 1'b1;
            bus.grant_id_o       = gnt;
            bus.fifo_push_data_o = bus.req_data_i[gnt*DATA_W +: DATA_W];
        end
        if (fire) begin
            bus.req_ready_o = N_REQ'(1) << gnt;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            lock_q  <= 1'b0;
            owner_q <= '0;
            cnt_q   <= '0;
            last_q  <= ID_W'(N_REQ - 1);
        end else if (fire) begin
            last_q <= gnt;
            if (cnt_next == CNT_W'(MAX_BURST)) begin
                // Burst complete: next scan starts after gnt.
                lock_q <= 1'b0;
                cnt_q  <= '0;
            end else begin
                lock_q  <= 1'b1;
                owner_q <= gnt;
                cnt_q   <= cnt_next;
            end
        end else if (lock_q && !bus.req_valid_i[owner_q]) begin
            // Owner went idle mid-burst: drop the partial burst.
            lock_q <= 1'b0;
            cnt_q  <= '0;
        end
    end
endmodule

// File: tb/tb_qs_fifo_rr_arb.sv
module tb_qs_fifo_rr_arb;
    localparam int DW = 8;
    localparam int N  = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst;
    logic [N-1:0]    valid;
    logic [N*DW-1:0] data;
    logic            full;

    qs_fifo_rr_arb_if #(.DATA_W(DW), .N_REQ(N)) bif0();
    qs_fifo_rr_arb_if #(.DATA_W(DW), .N_REQ(N)) bif1();

    assign bif0.req_valid_i = valid;
    assign bif0.req_data_i  = data;
    assign bif0.fifo_full_i = full;
    assign bif1.req_valid_i = valid;
    assign bif1.req_data_i  = data;
    assign bif1.fifo_full_i = full;

    qs_fifo_rr_arb #(.DATA_W(DW), .N_REQ(N), .MAX_BURST(2)) dut (
        .clk(clk), .reset(rst), .bus(bif0));
    qs_fifo_rr_arb #(.DATA_W(DW), .N_REQ(N), .MAX_BURST(1)) dut_rr (
        .clk(clk), .reset(rst), .bus(bif1));

    int checks = 0;
    int errors = 0;

    // Reference model: one record per instance (0: MAX_BURST=2, 1: MAX_BURST=1).
    typedef struct {
        bit lock;
        int owner;
        int last;
        int beats;
    } mst_t;
    mst_t m[2];
    int   mb[2] = '{2, 1};

    logic       e_gv[2];
    int         e_gid[2];
    logic       e_push[2];
    logic [7:0] e_data[2];
    logic [1:0] e_rdy[2];
    bit         e_cont[2];

    logic       o_gv[2];
    int         o_gid[2];
    logic       o_push[2];
    logic [7:0] o_data[2];
    logic [1:0] o_rdy[2];

    function automatic void model_reset(int j);
        m[j].lock  = 1'b0;
        m[j].owner = 0;
        m[j].last  = N - 1;
        m[j].beats = 0;
    endfunction

    function automatic void model_eval(int j);
        logic [1:0] one = 2'b01;
        bit found = 1'b0;
        e_gv[j] = 1'b0; e_gid[j] = 0; e_push[j] = 1'b0;
        e_data[j] = '0; e_rdy[j] = '0; e_cont[j] = 1'b0;
        if (rst || valid == '0) return;
        e_gv[j] = 1'b1;
        if (m[j].lock && valid[m[j].owner]) begin
            e_gid[j]  = m[j].owner;
            e_cont[j] = 1'b1;
        end else begin
            for (int k = 1; k <= N; k++) begin
                int i = (m[j].last + k) % N;
                if (!found && valid[i]) begin
                    e_gid[j] = i;
                    found = 1'b1;
                end
            end
        end
        e_data[j] = data[e_gid[j]*DW +: DW];
        e_push[j] = !full;
        if (e_push[j]) e_rdy[j] = one << e_gid[j];
    endfunction

    function automatic void model_update(int j);
        int n;
        if (rst) begin
            model_reset(j);
        end else if (e_push[j]) begin
            m[j].last = e_gid[j];
            n = e_cont[j] ? m[j].beats + 1 : 1;
            if (n == mb[j]) begin
                m[j].lock  = 1'b0;
                m[j].beats = 0;
            end else begin
                m[j].lock  = 1'b1;
                m[j].owner = e_gid[j];
                m[j].beats = n;
            end
        end else if (m[j].lock && !valid[m[j].owner]) begin
            m[j].lock  = 1'b0;
            m[j].beats = 0;
        end
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: compare both instances against the model mid-cycle,
    // then advance the model on the rising edge.
    task automatic step();
        @(negedge clk);
        o_gv[0] = bif0.grant_valid_o;   o_gv[1] = bif1.grant_valid_o;
        o_gid[0] = int'(bif0.grant_id_o); o_gid[1] = int'(bif1.grant_id_o);
        o_push[0] = bif0.fifo_push_o;   o_push[1] = bif1.fifo_push_o;
        o_data[0] = bif0.fifo_push_data_o; o_data[1] = bif1.fifo_push_data_o;
        o_rdy[0] = bif0.req_ready_o;    o_rdy[1] = bif1.req_ready_o;
        for (int j = 0; j < 2; j++) begin
            model_eval(j);
            chk($sformatf("i%0d grant_valid", j), 32'(o_gv[j]), 32'(e_gv[j]));
            chk($sformatf("i%0d grant_id", j), o_gid[j], e_gid[j]);
            chk($sformatf("i%0d push", j), 32'(o_push[j]), 32'(e_push[j]));
            chk($sformatf("i%0d push_data", j), 32'(o_data[j]), 32'(e_data[j]));
            chk($sformatf("i%0d ready", j), 32'(o_rdy[j]), 32'(e_rdy[j]));
            chk($sformatf("i%0d push_while_full", j), 32'(o_push[j] & full), 32'(0));
        end
        @(posedge clk);
        for (int j = 0; j < 2; j++) model_update(j);
        #1;
    endtask

    logic [7:0] s1_data[6] = '{8'h11, 8'h11, 8'h22, 8'h22, 8'h11, 8'h11};
    int         s1_gid[6]  = '{0, 0, 1, 1, 0, 0};
    logic [7:0] s2_data[4] = '{8'h11, 8'h22, 8'h11, 8'h22};
    logic [7:0] q[$];
    logic [7:0] popped;

    initial begin
        rst = 1'b1; valid = '0; data = '0; full = 1'b0;
        model_reset(0); model_reset(1);
        #1;

        // Reset ordering / pure round-robin
        valid = 2'b11; data = {8'h22, 8'h11};
        repeat (2) begin
            step();
            chk("s1 reset gv", 32'(o_gv[0]), 32'(0));
            chk("s1 reset rdy", 32'(o_rdy[0]), 32'(0));
        end
        rst = 1'b0;
        for (int c = 0; c < 6; c++) begin
            step();
            chk($sformatf("s1 data%0d", c), 32'(o_data[0]), 32'(s1_data[c]));
            chk($sformatf("s1 gid%0d", c), o_gid[0], s1_gid[c]);
            if (c < 4) chk($sformatf("s2 rr data%0d", c), 32'(o_data[1]), 32'(s2_data[c]));
        end

        // Backpressure
        valid = 2'b01; data = {8'h22, 8'h5A}; full = 1'b1;
        repeat (3) begin
            step();
            chk("s3 full push", 32'(o_push[0]), 32'(0));
            chk("s3 full rdy", 32'(o_rdy[0]), 32'(0));
            chk("s3 full gv", 32'(o_gv[0]), 32'(1));
            chk("s3 full gid", o_gid[0], 0);
        end
        full = 1'b0;
        step();
        chk("s3 release push", 32'(o_push[0]), 32'(1));
        chk("s3 release data", 32'(o_data[0]), 32'h5A);
        chk("s3 release rdy", 32'(o_rdy[0]), 32'(2'b01));

        // Early release
        rst = 1'b1; step(); rst = 1'b0;
        valid = 2'b01; data = {8'h00, 8'hAB};
        step();
        chk("s4 first data", 32'(o_data[0]), 32'hAB);
        valid = 2'b10; data = {8'hCC, 8'h00};
        step();
        chk("s4 switch data", 32'(o_data[0]), 32'hCC);
        chk("s4 switch gid", o_gid[0], 1);
        valid = 2'b11; data = {8'hCC, 8'hDD};
        step();
        chk("s4 cont data", 32'(o_data[0]), 32'hCC);
        chk("s4 cont gid", o_gid[0], 1);
        step();
        chk("s4 next data", 32'(o_data[0]), 32'hDD);
        chk("s4 next gid", o_gid[0], 0);

        // Reset mid-burst
        rst = 1'b1; step(); rst = 1'b0;
        valid = 2'b10; data = {8'h77, 8'h66};
        step();
        chk("s5 burst gid", o_gid[0], 1);
        rst = 1'b1; valid = 2'b11;
        step();
        chk("s5 reset gv", 32'(o_gv[0]), 32'(0));
        chk("s5 reset push", 32'(o_push[0]), 32'(0));
        rst = 1'b0;
        step();
        chk("s5 after gid", o_gid[0], 0);
        chk("s5 after push", 32'(o_push[0]), 32'(1));

        // Integration with a DEPTH=2 FIFO model
        rst = 1'b1; step(); rst = 1'b0;
        valid = 2'b01;
        data = {8'h00, 8'hAB}; full = (q.size() == 2);
        step(); if (o_push[0]) q.push_back(o_data[0]);
        data = {8'h00, 8'hCC}; full = (q.size() == 2);
        step(); if (o_push[0]) q.push_back(o_data[0]);
        data = {8'h00, 8'hEE}; full = (q.size() == 2);
        step();
        chk("s6 stall push", 32'(o_push[0]), 32'(0));
        chk("s6 stall rdy", 32'(o_rdy[0]), 32'(0));
        chk("s6 q size", q.size(), 2);
        if (q.size() > 0) begin
            popped = q.pop_front();
            chk("s6 pop0", 32'(popped), 32'hAB);
        end
        full = (q.size() == 2);
        step();
        chk("s6 EE push", 32'(o_push[0]), 32'(1));
        chk("s6 EE rdy", 32'(o_rdy[0]), 32'(2'b01));
        if (o_push[0]) q.push_back(o_data[0]);
        valid = '0; full = 1'b0;
        chk("s6 q size end", q.size(), 2);
        for (int p = 1; p < 3; p++) begin
            popped = (q.size() > 0) ? q.pop_front() : 8'h00;
            chk($sformatf("s6 pop%0d", p), 32'(popped), (p == 1) ? 32'hCC : 32'hEE);
        end

        // Randomized traffic against the model; producers obey hold-until-ready
        rst = 1'b1; step(); rst = 1'b0;
        for (int c = 0; c < 400; c++) begin
            rst  = ($urandom_range(0, 63) == 0);
            full = ($urandom_range(0, 3) == 0);
            for (int i = 0; i < N; i++) begin
                if (!(valid[i] && !o_rdy[0][i])) begin
                    valid[i] = ($urandom_range(0, 2) != 0);
                    data[i*DW +: DW] = 8'($urandom);
                end
            end
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/qs_fifo_rr_arb.md
Name: qs_fifo_rr_arb

Overview:
Round-robin push arbiter that shares one qs_fifo write port between N_REQ independent producers.
- Each producer presents data with a valid/ready handshake.
- The arbiter selects one producer per cycle and drives push_i/push_data_i of the FIFO, throttled by the FIFO's full_o.
- A grant can be held for up to MAX_BURST consecutive pushes, so bursts from one producer land contiguously in the FIFO.

Parameters:
- DATA_W, 8, data width in bits; must match the downstream qs_fifo DATA_W.
- N_REQ, 2, number of requesters, 2..8.
- MAX_BURST, 2, maximum consecutive pushes per grant, >=1. A value of 1 gives pure round-robin.
- ID_W, derived, max(1, clog2(N_REQ)). Not user-overridable.

Ports:
- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  synchronous, active-high reset
- req_valid_i  in  N_REQ  per-requester data-valid
- req_data_i  in  N_REQ*DATA_W  packed data; requester i occupies bits [i*DATA_W +: DATA_W]
- req_ready_o  out  N_REQ  per-requester accept; a beat transfers when valid and ready are both 1
- fifo_push_o  out  1  to qs_fifo push_i
- fifo_push_data_o  out  DATA_W  to qs_fifo push_data_i
- fifo_full_i  in  1  from qs_fifo full_o
- grant_valid_o  out  1  a requester is selected this cycle
- grant_id_o  out  ID_W  index of the selected requester; 0 when grant_valid_o=0

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high.
- State registers:
  - lock_q (1b)
  - owner_q (ID_W)
  - last_q (ID_W)
  - cnt_q (clog2(MAX_BURST+1) bits)
- Reset values:
  - lock_q=0, owner_q=0, cnt_q=0
  - last_q=N_REQ-1, so requester 0 has first priority after reset.
- Outputs during reset: while reset=1, all outputs are forced to 0, regardless of inputs.
- Grant selection (combinational from state and inputs):
  - CONTINUE: if lock_q=1 and req_valid_i[owner_q]=1, then gnt=owner_q.
  - Otherwise, SCAN: gnt is the first i with req_valid_i[i]=1, scanning last_q+1, last_q+2, ... modulo N_REQ.
  - grant_valid_o=1 if any request is valid.
- Fire and outputs:
  - fire = grant_valid_o & ~fifo_full_i.
  - fifo_push_o = fire.
  - req_ready_o is one-hot at gnt when fire=1, else 0.
  - fifo_push_data_o = req_data_i slice for gnt. It equals 0 when grant_valid_o=0.
- Zero latency: the producer-to-FIFO push happens in the same cycle; there are no internal data registers.
- On fire, at the clock edge:
  - last_q <= gnt.
  - cnt_next = (CONTINUE) ? cnt_q+1 : 1.
  - If cnt_next==MAX_BURST: lock_q<=0 and cnt_q<=0 (burst complete; next scan starts at gnt+1).
  - Otherwise: lock_q<=1, owner_q<=gnt, cnt_q<=cnt_next.
- No fire, lock_q=1, owner not valid: lock_q<=0 and cnt_q<=0 (early release). A partial burst does not carry over.
- No fire due to full:
  - All state holds and the grant does not move.
  - If inputs are stable, the same requester is offered next cycle.
- Producer rule: a producer must hold valid and data stable until it sees ready. The arbiter does not check this.
- Simultaneous full deassert and new valid: a push occurs in the first cycle where fifo_full_i=0.
- FIFO safety: the arbiter never asserts fifo_push_o while fifo_full_i=1.
- Reset mid-burst: the lock is dropped and priority returns to requester 0 on the first cycle after reset deasserts.

Test Plan:
All scenarios use DATA_W=8, N_REQ=2, MAX_BURST=2 unless noted.
1. Reset ordering:
   - Stimulus: hold reset 2 cycles with req_valid_i=2'b11; then release, with full=0, req0 data=0x11, req1 data=0x22 held constant.
   - Required response: all outputs 0 during reset. After release, the push sequence is 0x11,0x11,0x22,0x22,0x11,0x11, and grant_id_o is 0,0,1,1,0,0.
2. Pure round-robin:
   - Stimulus: same as scenario 1 with MAX_BURST=1.
   - Required response: pushes alternate 0x11,0x22,0x11,0x22 every cycle.
3. Backpressure:
   - Stimulus: fifo_full_i=1 with req0 valid, data 0x5A, for 3 cycles; then full=0.
   - Required response: while full, fifo_push_o=0, req_ready_o=0, grant_valid_o=1, grant_id_o=0 stable. 0x5A is pushed in the first cycle with full=0, with req_ready_o=2'b01.
4. Early release:
   - Stimulus: req0 pushes 0xAB (lock taken, cnt=1); next cycle req0 valid=0 and req1 valid with 0xCC.
   - Required response: 0xCC is pushed that cycle with grant_id_o=1. Then req0 valid again with 0xDD and req1 still valid: req1 continues its burst first, pushing 0xCC a second time before 0xDD.
5. Reset mid-burst:
   - Stimulus: after req1 pushes one beat (lock held on 1), assert reset 1 cycle with both valid.
   - Required response: outputs 0 during reset; the next grant after release is requester 0.
6. Integration with qs_fifo DEPTH=2:
   - Stimulus: req0 offers 0xAB, 0xCC, 0xEE back-to-back.
   - Required response: 0xAB and 0xCC are pushed. 0xEE stalls (ready=0) while full_o=1, and is pushed in the cycle after a pop clears full_o. Pop order is 0xAB, 0xCC, 0xEE.
